// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - round-robin register file writeback arbiter with pending-write scoreboard
//
// Purpose:
//   Picks one of NUM_REQ writeback requesters per cycle in round-robin order
//   and forwards the chosen write to the register file one cycle later. A
//   scoreboard of pending destinations is kept alongside. The decoder sets an
//   entry at issue, and the entry clears when the matching write leaves the
//   block. Register 0 is hardwired: writes to it are accepted and dropped, and
//   it can never be marked pending.
//
// Ports:
//   clock        in   sole clock, rising edge
//   reset        in   synchronous, active-high
//   req_valid    in   [NUM_REQ]            per-requester write request
//   req_loc      in   [NUM_REQ*LOC_WIDTH]  per-requester destination, slice i at i*LOC_WIDTH
//   req_data     in   [NUM_REQ*DATA_WIDTH] per-requester data, slice i at i*DATA_WIDTH
//   req_ready    out  [NUM_REQ]            one-hot-or-zero grant (combinational)
//   wr_en        out  register file write enable (registered)
//   wr_loc       out  [LOC_WIDTH]  register file write index (registered)
//   wr_data      out  [DATA_WIDTH] register file write data (registered)
//   reserve_en   in   mark reserve_loc as having a pending write
//   reserve_loc  in   [LOC_WIDTH] index being reserved
//   query_loc_1  in   [LOC_WIDTH] operand index 1
//   query_loc_2  in   [LOC_WIDTH] operand index 2
//   query_busy_1 out  operand 1 has a pending write
//   query_busy_2 out  operand 2 has a pending write
//   busy_mask    out  [2**LOC_WIDTH] full scoreboard
//   conflict     out  sticky flag: a reservation hit an index that was already pending

module regfile_write_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int LOC_WIDTH  = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*LOC_WIDTH-1:0]    req_loc,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic                            wr_en,
  output logic [LOC_WIDTH-1:0]            wr_loc,
  output logic [DATA_WIDTH-1:0]           wr_data,
  input  logic                            reserve_en,
  input  logic [LOC_WIDTH-1:0]            reserve_loc,
  input  logic [LOC_WIDTH-1:0]            query_loc_1,
  input  logic [LOC_WIDTH-1:0]            query_loc_2,
  output logic                            query_busy_1,
  output logic                            query_busy_2,
  output logic [(1<<LOC_WIDTH)-1:0]       busy_mask,
  output logic                            conflict
);

  localparam int NUM_LOC = 1 << LOC_WIDTH;
  localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [PTR_W-1:0]      r_rr_ptr;
  logic                  r_wr_en;
  logic [LOC_WIDTH-1:0]  r_wr_loc;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic [NUM_LOC-1:0]    r_busy;
  logic                  r_conflict;

  // ---------------------------------------------------------------------------
  // Round-robin grant
  // ---------------------------------------------------------------------------
  logic                  w_found;
  logic [PTR_W-1:0]      w_gnt_idx;
  logic [PTR_W-1:0]      w_cand;
  logic [NUM_REQ-1:0]    w_req_ready;

  // Walk the requesters starting at the pointer and stop at the first valid
  // one. Reset forces a zero grant, so nothing transfers while reset is high.
  always_comb begin
    w_found     = 1'b0;
    w_gnt_idx   = '0;
    w_cand      = '0;
    w_req_ready = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = PTR_W'((int'(r_rr_ptr) + k) % NUM_REQ);
      if (!w_found && !reset && req_valid[w_cand]) begin
        w_found   = 1'b1;
        w_gnt_idx = w_cand;
      end
    end
    if (w_found) begin
      w_req_ready[w_gnt_idx] = 1'b1;
    end
  end

  // The granted requester's fields. These are only used when w_found is set.
  logic [LOC_WIDTH-1:0]  w_sel_loc;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic [PTR_W-1:0]      w_ptr_next;

  always_comb begin
    w_sel_loc  = req_loc[int'(w_gnt_idx)*LOC_WIDTH +: LOC_WIDTH];
    w_sel_data = req_data[int'(w_gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
    if (w_gnt_idx == PTR_W'(NUM_REQ - 1)) begin
      w_ptr_next = '0;
    end else begin
      w_ptr_next = w_gnt_idx + PTR_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard next state
  // ---------------------------------------------------------------------------
  logic [NUM_LOC-1:0] w_busy_next;
  logic               w_reserve_live;
  logic               w_clear_same;
  logic               w_conflict_set;

  // The clear comes from the registered write that is leaving this cycle. It
  // is applied before the set, so a reservation of the same index in the same
  // cycle wins and the entry stays pending for the new producer.
  always_comb begin
    w_reserve_live = reserve_en && (reserve_loc != '0);
    w_clear_same   = r_wr_en && (r_wr_loc == reserve_loc);
    w_busy_next    = r_busy;
    if (r_wr_en) begin
      w_busy_next[r_wr_loc] = 1'b0;
    end
    if (w_reserve_live) begin
      w_busy_next[reserve_loc] = 1'b1;
    end
    w_busy_next[0] = 1'b0;
    // Re-reserving an index that is still pending means two producers are in
    // flight to one register. A write retiring the old producer in the same
    // cycle makes the reservation legal.
    w_conflict_set = w_reserve_live && r_busy[reserve_loc] && !w_clear_same;
  end

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rr_ptr   <= '0;
      r_wr_en    <= 1'b0;
      r_wr_loc   <= '0;
      r_wr_data  <= '0;
      r_busy     <= '0;
      r_conflict <= 1'b0;
    end else begin
      if (w_found) begin
        r_rr_ptr <= w_ptr_next;
      end
      // A write to register 0 is consumed but never reaches the register
      // file. The last real write's index and data stay on the outputs.
      if (w_found && (w_sel_loc != '0)) begin
        r_wr_en   <= 1'b1;
        r_wr_loc  <= w_sel_loc;
        r_wr_data <= w_sel_data;
      end else begin
        r_wr_en   <= 1'b0;
      end
      r_busy <= w_busy_next;
      if (w_conflict_set) begin
        r_conflict <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign req_ready    = w_req_ready;
  assign wr_en        = r_wr_en;
  assign wr_loc       = r_wr_loc;
  assign wr_data      = r_wr_data;
  assign busy_mask    = r_busy;
  assign conflict     = r_conflict;
  // Queries see only the registered scoreboard. A reservation or clear made
  // this cycle becomes visible on the next one.
  assign query_busy_1 = r_busy[query_loc_1];
  assign query_busy_2 = r_busy[query_loc_2];

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - table-driven bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

  localparam int NR = 3;
  localparam int LW = 4;
  localparam int DW = 32;

  logic                clock = 1'b0;
  logic                reset;
  logic [NR-1:0]       req_valid;
  logic [NR*LW-1:0]    req_loc;
  logic [NR*DW-1:0]    req_data;
  logic [NR-1:0]       req_ready;
  logic                wr_en;
  logic [LW-1:0]       wr_loc;
  logic [DW-1:0]       wr_data;
  logic                reserve_en;
  logic [LW-1:0]       reserve_loc;
  logic [LW-1:0]       query_loc_1;
  logic [LW-1:0]       query_loc_2;
  logic                query_busy_1;
  logic                query_busy_2;
  logic [(1<<LW)-1:0]  busy_mask;
  logic                conflict;

  int n_pass = 0;
  int n_total = 0;

  regfile_write_arbiter #(.NUM_REQ(NR), .LOC_WIDTH(LW), .DATA_WIDTH(DW)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_loc(req_loc), .req_data(req_data), .req_ready(req_ready),
    .wr_en(wr_en), .wr_loc(wr_loc), .wr_data(wr_data),
    .reserve_en(reserve_en), .reserve_loc(reserve_loc),
    .query_loc_1(query_loc_1), .query_loc_2(query_loc_2),
    .query_busy_1(query_busy_1), .query_busy_2(query_busy_2),
    .busy_mask(busy_mask), .conflict(conflict)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic [2:0]  valid;
    logic [3:0]  l2, l1, l0;
    logic [31:0] d2, d1, d0;
    logic        res_en;
    logic [3:0]  res_loc;
    logic [3:0]  q1;
    // expected before the edge (combinational)
    logic [2:0]  e_ready;
    logic        e_q1, e_q2;
    // expected after the edge (registered)
    logic        e_wen;
    logic [3:0]  e_wloc;
    logic [31:0] e_wdata;
    logic [15:0] e_busy;
    logic        e_conf;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s step %0d: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic drive(input vec_t v);
    reset       = v.rst;
    req_valid   = v.valid;
    req_loc     = {v.l2, v.l1, v.l0};
    req_data    = {v.d2, v.d1, v.d0};
    reserve_en  = v.res_en;
    reserve_loc = v.res_loc;
    query_loc_1 = v.q1;
    query_loc_2 = 4'd7;
  endtask

  // Drive at edge+1, check combinational outputs at edge+3, then check the
  // registered results 1 unit after the next rising edge.
  task automatic run_vec(input vec_t v, input int idx);
    drive(v);
    #2;
    chk("req_ready", idx, 32'(req_ready), 32'(v.e_ready));
    chk("query_busy_1", idx, 32'(query_busy_1), 32'(v.e_q1));
    chk("query_busy_2", idx, 32'(query_busy_2), 32'(v.e_q2));
    @(posedge clock);
    #1;
    chk("wr_en", idx, 32'(wr_en), 32'(v.e_wen));
    chk("wr_loc", idx, 32'(wr_loc), 32'(v.e_wloc));
    chk("wr_data", idx, wr_data, v.e_wdata);
    chk("busy_mask", idx, 32'(busy_mask), 32'(v.e_busy));
    chk("conflict", idx, 32'(conflict), 32'(v.e_conf));
  endtask

  function automatic vec_t mk(
    input logic rst, input logic [2:0] valid,
    input logic [3:0] l2, input logic [3:0] l1, input logic [3:0] l0,
    input logic [31:0] d2, input logic [31:0] d1, input logic [31:0] d0,
    input logic res_en, input logic [3:0] res_loc, input logic [3:0] q1,
    input logic [2:0] e_ready, input logic e_q1, input logic e_q2,
    input logic e_wen, input logic [3:0] e_wloc, input logic [31:0] e_wdata,
    input logic [15:0] e_busy, input logic e_conf);
    vec_t v;
    v.rst = rst; v.valid = valid; v.l2 = l2; v.l1 = l1; v.l0 = l0;
    v.d2 = d2; v.d1 = d1; v.d0 = d0; v.res_en = res_en; v.res_loc = res_loc; v.q1 = q1;
    v.e_ready = e_ready; v.e_q1 = e_q1; v.e_q2 = e_q2; v.e_wen = e_wen;
    v.e_wloc = e_wloc; v.e_wdata = e_wdata; v.e_busy = e_busy; v.e_conf = e_conf;
    return v;
  endfunction

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached, expected finish before 20000");
    $fatal(1, "watchdog");
  end

  initial begin
    //           rst valid   l2 l1 l0  d2     d1     d0     ren rloc q1   ready  q1 q2 wen wloc wdata   busy      conf
    // reset, then three held requests granted 0,1,2 in turn
    vecs.push_back(mk(1, 3'b111, 3, 2, 1, 32'hC, 32'hB, 32'hA, 0, 0, 0,  3'b000, 0, 0, 0, 0, 32'h0,  16'h0000, 0));
    vecs.push_back(mk(0, 3'b111, 3, 2, 1, 32'hC, 32'hB, 32'hA, 0, 0, 0,  3'b001, 0, 0, 1, 1, 32'hA,  16'h0000, 0));
    vecs.push_back(mk(0, 3'b111, 3, 2, 1, 32'hC, 32'hB, 32'hA, 0, 0, 0,  3'b010, 0, 0, 1, 2, 32'hB,  16'h0000, 0));
    vecs.push_back(mk(0, 3'b111, 3, 2, 1, 32'hC, 32'hB, 32'hA, 0, 0, 0,  3'b100, 0, 0, 1, 3, 32'hC,  16'h0000, 0));
    // pointer 0, only req 1 -> pointer goes to 2
    vecs.push_back(mk(0, 3'b010, 3, 2, 1, 32'hC, 32'hB, 32'hA, 0, 0, 0,  3'b010, 0, 0, 1, 2, 32'hB,  16'h0000, 0));
    // pointer 2 with 011 -> wraps to grant 0, pointer 1
    vecs.push_back(mk(0, 3'b011, 3, 2, 1, 32'hC, 32'hB, 32'hA, 0, 0, 0,  3'b001, 0, 0, 1, 1, 32'hA,  16'h0000, 0));
    // pointer 1 confirmed: 011 grants 1
    vecs.push_back(mk(0, 3'b011, 3, 2, 1, 32'hC, 32'hB, 32'hA, 0, 0, 0,  3'b010, 0, 0, 1, 2, 32'hB,  16'h0000, 0));
    // idle: wr_en drops, loc/data hold
    vecs.push_back(mk(0, 3'b000, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0,  3'b000, 0, 0, 0, 2, 32'hB,  16'h0000, 0));
    // reserve x5; query not yet visible
    vecs.push_back(mk(0, 3'b000, 0, 0, 0, 32'h0, 32'h0, 32'h0, 1, 5, 5,  3'b000, 0, 0, 0, 2, 32'hB,  16'h0020, 0));
    // req 1 writes x5=0x55 (pointer 2 -> search 2,0,1)
    vecs.push_back(mk(0, 3'b010, 0, 5, 0, 32'h0, 32'h55, 32'h0, 0, 0, 5, 3'b010, 1, 0, 1, 5, 32'h55, 16'h0020, 0));
    // wr_en active this cycle clears busy[5]
    vecs.push_back(mk(0, 3'b000, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 5,  3'b000, 1, 0, 0, 5, 32'h55, 16'h0000, 0));
    vecs.push_back(mk(0, 3'b000, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 5,  3'b000, 0, 0, 0, 5, 32'h55, 16'h0000, 0));
    // write to x0: accepted, no write enable
    vecs.push_back(mk(0, 3'b001, 0, 0, 0, 32'h0, 32'h0, 32'hFF, 0, 0, 0, 3'b001, 0, 0, 0, 5, 32'h55, 16'h0000, 0));
    // double reservation of x7 -> sticky conflict
    vecs.push_back(mk(0, 3'b000, 0, 0, 0, 32'h0, 32'h0, 32'h0, 1, 7, 7,  3'b000, 0, 0, 0, 5, 32'h55, 16'h0080, 0));
    vecs.push_back(mk(0, 3'b000, 0, 0, 0, 32'h0, 32'h0, 32'h0, 1, 7, 7,  3'b000, 1, 1, 0, 5, 32'h55, 16'h0080, 1));
    vecs.push_back(mk(0, 3'b000, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 7,  3'b000, 1, 1, 0, 5, 32'h55, 16'h0080, 1));
    // reset clears conflict and scoreboard
    vecs.push_back(mk(1, 3'b000, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 7,  3'b000, 1, 1, 0, 0, 32'h0,  16'h0000, 0));
    // reserve x7, write x7, re-reserve x7 while the write clears it
    vecs.push_back(mk(0, 3'b000, 0, 0, 0, 32'h0, 32'h0, 32'h0, 1, 7, 7,  3'b000, 0, 0, 0, 0, 32'h0,  16'h0080, 0));
    vecs.push_back(mk(0, 3'b001, 0, 0, 7, 32'h0, 32'h0, 32'h77, 0, 0, 7, 3'b001, 1, 1, 1, 7, 32'h77, 16'h0080, 0));
    vecs.push_back(mk(0, 3'b000, 0, 0, 0, 32'h0, 32'h0, 32'h0, 1, 7, 7,  3'b000, 1, 1, 0, 7, 32'h77, 16'h0080, 0));

    reset = 1'b1; req_valid = '0; req_loc = '0; req_data = '0;
    reserve_en = 1'b0; reserve_loc = '0; query_loc_1 = '0; query_loc_2 = '0;
    @(posedge clock);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i], i);
    end

    // Reset one cycle after a transfer: pending write and reservations are
    // discarded, and the pointer restarts at 0 (pointer is 1 here).
    reset = 1'b0; req_valid = 3'b010; req_loc = {4'd0, 4'd9, 4'd0};
    req_data = {32'h0, 32'h99, 32'h0}; reserve_en = 1'b1; reserve_loc = 4'd3;
    #2;
    chk("seq_ready_before_reset", 100, 32'(req_ready), 32'h2);
    @(posedge clock); #1;
    chk("seq_wr_en_pre", 101, 32'(wr_en), 32'h1);
    chk("seq_busy_pre", 102, 32'(busy_mask), 32'h0088);
    reset = 1'b1; req_valid = 3'b111; req_loc = {4'd3, 4'd2, 4'd1};
    req_data = {32'hC, 32'hB, 32'hA}; reserve_en = 1'b0;
    #2;
    chk("seq_ready_in_reset", 103, 32'(req_ready), 32'h0);
    @(posedge clock); #1;
    chk("seq_wr_en_reset", 104, 32'(wr_en), 32'h0);
    chk("seq_wr_loc_reset", 105, 32'(wr_loc), 32'h0);
    chk("seq_busy_reset", 106, 32'(busy_mask), 32'h0);
    // After reset the pointer is 0; reserving index 0 is ignored.
    reset = 1'b0; reserve_en = 1'b1; reserve_loc = 4'd0;
    #2;
    chk("seq_ready_after_reset", 107, 32'(req_ready), 32'h1);
    @(posedge clock); #1;
    chk("seq_wr_loc_after", 108, 32'(wr_loc), 32'h1);
    chk("seq_wr_data_after", 109, wr_data, 32'hA);
    chk("seq_busy_x0_ignored", 110, 32'(busy_mask), 32'h0);
    reserve_en = 1'b0; req_valid = '0;
    #2;
    chk("seq_ready_idle", 111, 32'(req_ready), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3, number of writeback requesters (2..8).
REQ-002 Parameter LOC_WIDTH, default 4, register index width (16 registers).
REQ-003 Parameter DATA_WIDTH, default 32, register data width.
REQ-004 Port: clock  in  1  sole clock; all state updates on rising edge.
REQ-005 Port: reset  in  1  synchronous, active-high reset.
REQ-006 Port: req_valid  in  NUM_REQ  per-requester write request.
REQ-007 Port: req_loc  in  NUM_REQ*LOC_WIDTH  per-requester destination index; slice i = bits [i*LOC_WIDTH +: LOC_WIDTH].
REQ-008 Port: req_data  in  NUM_REQ*DATA_WIDTH  per-requester write data; sliced as req_loc.
REQ-009 Port: req_ready  out  NUM_REQ  one-hot-or-zero grant.
REQ-010 Port: wr_en  out  1  register file write enable (drives do_write).
REQ-011 Port: wr_loc  out  LOC_WIDTH  register file write index.
REQ-012 Port: wr_data  out  DATA_WIDTH  register file write data.
REQ-013 Port: reserve_en  in  1  decoder marks a destination pending at issue.
REQ-014 Port: reserve_loc  in  LOC_WIDTH  index being reserved.
REQ-015 Port: query_loc_1, query_loc_2  in  LOC_WIDTH each  operand indices under test.
REQ-016 Port: query_busy_1, query_busy_2  out  1 each  operand has pending write.
REQ-017 Port: busy_mask  out  2**LOC_WIDTH  full scoreboard.
REQ-018 Port: conflict  out  1  sticky error flag.

Function
REQ-019 The block SHALL keep a round-robin pointer rr_ptr (0..NUM_REQ-1).
REQ-020 Grant SHALL be the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
REQ-021 req_ready SHALL be combinational: 1 only on the granted index, all zero when no req_valid.
REQ-022 Transfer occurs when req_valid[i] && req_ready[i]; at most one transfer per cycle.
REQ-023 On transfer from i, rr_ptr SHALL become (i+1) mod NUM_REQ next cycle; no transfer leaves rr_ptr unchanged.
REQ-024 Requesters hold valid/loc/data stable until ready; block does not latch a non-granted request.
REQ-025 Write output is registered: transfer in cycle N SHALL give wr_en/wr_loc/wr_data valid in cycle N+1 only.
REQ-026 Transfer with req_loc=0 SHALL be accepted (ready=1) but wr_en SHALL stay 0 in cycle N+1.
REQ-027 No transfer in cycle N SHALL give wr_en=0 in N+1; wr_loc/wr_data hold last value.
REQ-028 Scoreboard: busy[n] SHALL set next cycle on reserve_en with reserve_loc=n, n!=0.
REQ-029 busy[n] SHALL clear next cycle when wr_en=1 and wr_loc=n.
REQ-030 Simultaneous set and clear of the same n: set wins, busy[n]=1.
REQ-031 busy[0] SHALL always read 0; reserve of index 0 ignored.
REQ-032 query_busy_k = busy[query_loc_k], combinational from registered busy, no bypass.
REQ-033 reserve_en to an index already busy (and not cleared same cycle) SHALL set conflict=1; conflict stays 1 until reset.
REQ-034 A transfer to an index whose busy bit is 0 is legal; it writes, leaves busy 0, no conflict.

Reset
REQ-035 With reset=1 at a rising edge: rr_ptr=0, wr_en=0, wr_loc=0, wr_data=0, busy_mask=0, conflict=0.
REQ-036 During reset cycles req_ready SHALL be all zero and no transfer occurs.
REQ-037 Reset mid-operation SHALL discard a pending output write (wr_en=0 next cycle) and all reservations.

Verification
REQ-038 Reset, then req_valid=3'b111, locs 1/2/3, data 0xA/0xB/0xC held -> grants 0,1,2 on consecutive cycles; wr_en pulses write x1=0xA, x2=0xB, x3=0xC one cycle after each grant.
REQ-039 rr_ptr=2 with req_valid=3'b011 -> grant index 0; rr_ptr becomes 1.
REQ-040 reserve x5; next cycle query_loc_1=5 -> query_busy_1=1; req 1 writes x5=0x55 -> busy[5] clears the cycle after wr_en, query_busy_1=0.
REQ-041 Req 0 writes x0=0xFF -> req_ready[0]=1, wr_en stays 0, busy_mask unchanged.
REQ-042 reserve x7 twice with no intervening write -> conflict=1 and stays 1; reserve x7 in the same cycle wr_en clears x7 -> busy[7]=1, no conflict.
REQ-043 Transfer in cycle N with reset=1 in cycle N+1 -> wr_en=0 after that edge, busy_mask=0, rr_ptr=0.
